// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the IF fetch port
// and the data load/store port. Round-robin on ties, ready handshake with a
// per-access timeout, registered one-cycle acknowledge per port and
// combinational stall requests back to the pipeline.
module mem_port_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 13,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   // instruction-fetch port
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic                  if_ack_o,
   output logic                  if_err_o,
   output logic [DATA_WIDTH-1:0] if_rdata_o,
   // data port
   input  logic                  d_req_i,
   input  logic                  d_we_i,
   input  logic [3:0]            d_be_i,
   input  logic [ADDR_WIDTH-1:0] d_addr_i,
   input  logic [DATA_WIDTH-1:0] d_wdata_i,
   output logic                  d_ack_o,
   output logic                  d_err_o,
   output logic [DATA_WIDTH-1:0] d_rdata_o,
   // pipeline stalls
   output logic                  stall_if_o,
   output logic                  stall_mem_o,
   // memory side
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   input  logic                  mem_ready_i
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LP_WAIT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_last_grant_d;   // 0 = IF granted last, 1 = data
   logic [CW-1:0]         r_wait;

   logic                  r_if_ack;
   logic                  r_if_err;
   logic [DATA_WIDTH-1:0] r_if_rdata;
   logic                  r_d_ack;
   logic                  r_d_err;
   logic [DATA_WIDTH-1:0] r_d_rdata;

   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [3:0]            r_mem_be;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;

   logic                  w_grant_d;
   logic                  w_grant_i;
   logic                  w_timeout;

   // Arbitration: data wins if alone, or on a tie when IF was granted last.
   always_comb begin
      w_grant_d = d_req_i & (~if_req_i | ~r_last_grant_d);
      w_grant_i = if_req_i & ~w_grant_d;
      w_timeout = (r_wait == LP_WAIT_LAST);
   end

   // Access sequencer: grant, hold payload, complete on ready or timeout.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state        <= ST_IDLE;
         r_last_grant_d <= 1'b0;
         r_wait         <= '0;
         r_if_ack       <= 1'b0;
         r_if_err       <= 1'b0;
         r_if_rdata     <= '0;
         r_d_ack        <= 1'b0;
         r_d_err        <= 1'b0;
         r_d_rdata      <= '0;
         r_mem_req      <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_be       <= '0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
      end else begin
         r_if_ack <= 1'b0;
         r_if_err <= 1'b0;
         r_d_ack  <= 1'b0;
         r_d_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_wait <= '0;
               if (w_grant_d) begin
                  r_state        <= ST_BUSY_D;
                  r_last_grant_d <= 1'b1;
                  r_mem_req      <= 1'b1;
                  r_mem_we       <= d_we_i;
                  r_mem_be       <= d_be_i;
                  r_mem_addr     <= d_addr_i;
                  r_mem_wdata    <= d_wdata_i;
               end else if (w_grant_i) begin
                  r_state        <= ST_BUSY_I;
                  r_last_grant_d <= 1'b0;
                  r_mem_req      <= 1'b1;
                  r_mem_we       <= 1'b0;
                  r_mem_be       <= 4'hF;
                  r_mem_addr     <= if_addr_i;
                  r_mem_wdata    <= '0;
               end
            end
            ST_BUSY_I: begin
               if (mem_ready_i) begin
                  r_if_rdata <= mem_rdata_i;
                  r_if_ack   <= 1'b1;
                  r_mem_req  <= 1'b0;
                  r_state    <= ST_IDLE;
               end else if (w_timeout) begin
                  r_if_rdata <= '0;
                  r_if_ack   <= 1'b1;
                  r_if_err   <= 1'b1;
                  r_mem_req  <= 1'b0;
                  r_state    <= ST_IDLE;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            ST_BUSY_D: begin
               if (mem_ready_i) begin
                  if (!r_mem_we) begin
                     r_d_rdata <= mem_rdata_i;
                  end
                  r_d_ack   <= 1'b1;
                  r_mem_req <= 1'b0;
                  r_state   <= ST_IDLE;
               end else if (w_timeout) begin
                  r_d_rdata <= '0;
                  r_d_ack   <= 1'b1;
                  r_d_err   <= 1'b1;
                  r_mem_req <= 1'b0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   // Output mapping; stalls are combinational so the ack cycle releases them.
   always_comb begin
      if_ack_o    = r_if_ack;
      if_err_o    = r_if_err;
      if_rdata_o  = r_if_rdata;
      d_ack_o     = r_d_ack;
      d_err_o     = r_d_err;
      d_rdata_o   = r_d_rdata;
      mem_req_o   = r_mem_req;
      mem_we_o    = r_mem_we;
      mem_be_o    = r_mem_be;
      mem_addr_o  = r_mem_addr;
      mem_wdata_o = r_mem_wdata;
      stall_if_o  = if_req_i & ~r_if_ack;
      stall_mem_o = d_req_i & ~r_d_ack;
   end

endmodule
